// File: rtl/spi_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module  : spi_frame_decoder
// Brief   : Decodes ADDR/COUNT/DATA/CHK byte frames into register writes.
// Revision: 1.0
// ============================================================================
module spi_frame_decoder #(
   parameter int WORD_BYTES = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    frame_active,
   input  logic [7:0]              byte_in,
   input  logic                    byte_valid,
   output logic                    wr_en,
   output logic [7:0]              wr_addr,
   output logic [8*WORD_BYTES-1:0] wr_data,
   output logic                    frame_done,
   output logic                    frame_err,
   output logic                    busy
);

   localparam int IDXW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
   localparam logic [IDXW-1:0] c_LAST_IDX = IDXW'(WORD_BYTES - 1);

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_GET_COUNT = 2'd1;
   localparam logic [1:0] S_DATA      = 2'd2;
   localparam logic [1:0] S_CHECK     = 2'd3;

   logic [1:0]              r_state;
   logic [7:0]              r_addr;
   logic [7:0]              r_count;
   logic [IDXW-1:0]         r_byte_idx;
   logic [7:0]              r_xor;
   logic [8*WORD_BYTES-1:0] r_buf;
   logic                    r_wr_en;
   logic [7:0]              r_wr_addr;
   logic [8*WORD_BYTES-1:0] r_wr_data;
   logic                    r_done;
   logic                    r_err;
   logic                    r_busy;

   logic                    w_accept;
   logic [8*WORD_BYTES-1:0] w_word;

   assign w_accept = byte_valid && frame_active;

   // The final byte of a word goes straight to the output, not via r_buf.
   always_comb begin
      w_word = r_buf;
      w_word[8*(WORD_BYTES-1) +: 8] = byte_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_addr     <= 8'd0;
         r_count    <= 8'd0;
         r_byte_idx <= '0;
         r_xor      <= 8'd0;
         r_buf      <= '0;
         r_wr_en    <= 1'b0;
         r_wr_addr  <= 8'd0;
         r_wr_data  <= '0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_wr_en <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         // Abort takes priority over any byte arriving in the same cycle.
         if (r_state != S_IDLE && !frame_active) begin
            r_err      <= 1'b1;
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_count    <= 8'd0;
            r_byte_idx <= '0;
            r_xor      <= 8'd0;
            r_buf      <= '0;
         end else if (w_accept) begin
            case (r_state)
               S_IDLE: begin
                  r_addr  <= byte_in;
                  r_xor   <= byte_in;
                  r_busy  <= 1'b1;
                  r_state <= S_GET_COUNT;
               end
               S_GET_COUNT: begin
                  r_xor      <= r_xor ^ byte_in;
                  r_count    <= byte_in;
                  r_byte_idx <= '0;
                  r_state    <= (byte_in == 8'd0) ? S_CHECK : S_DATA;
               end
               S_DATA: begin
                  r_xor <= r_xor ^ byte_in;
                  if (r_byte_idx == c_LAST_IDX) begin
                     r_wr_en    <= 1'b1;
                     r_wr_addr  <= r_addr;
                     r_wr_data  <= w_word;
                     r_addr     <= r_addr + 8'd1;
                     r_count    <= r_count - 8'd1;
                     r_byte_idx <= '0;
                     if (r_count == 8'd1) r_state <= S_CHECK;
                  end else begin
                     r_buf[8*int'(r_byte_idx) +: 8] <= byte_in;
                     r_byte_idx <= r_byte_idx + 1'b1;
                  end
               end
               default: begin
                  r_done  <= (byte_in == r_xor);
                  r_err   <= (byte_in != r_xor);
                  r_xor   <= 8'd0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign wr_en      = r_wr_en;
   assign wr_addr    = r_wr_addr;
   assign wr_data    = r_wr_data;
   assign frame_done = r_done;
   assign frame_err  = r_err;
   assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_frame_decoder
// Brief   : Directed self-checking bench for spi_frame_decoder.
// Revision: 1.0
// ============================================================================
module tb_spi_frame_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        frame_active;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        wr_en;
   logic [7:0]  wr_addr;
   logic [15:0] wr_data;
   logic        frame_done;
   logic        frame_err;
   logic        busy;

   int total = 0;
   int bad   = 0;

   logic [7:0]  q_addr[$];
   logic [15:0] q_data[$];
   int          n_done;
   int          n_err;

   spi_frame_decoder #(.WORD_BYTES(2)) dut (
      .clk          (clk),
      .rst          (rst),
      .frame_active (frame_active),
      .byte_in      (byte_in),
      .byte_valid   (byte_valid),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .frame_done   (frame_done),
      .frame_err    (frame_err),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_en) begin
         q_addr.push_back(wr_addr);
         q_data.push_back(wr_data);
      end
      if (frame_done) n_done++;
      if (frame_err)  n_err++;
   end

   task automatic clear_log();
      q_addr.delete();
      q_data.delete();
      n_done = 0;
      n_err  = 0;
   endtask

   // Byte presented before the edge; returns #1 after the edge that accepts it.
   task automatic send(input logic [7:0] b);
      byte_in      = b;
      byte_valid   = 1'b1;
      frame_active = 1'b1;
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_nominal();
      send(8'h10); send(8'h02); send(8'h34); send(8'h12);
      send(8'hCD); send(8'hAB); send(8'h52);
   endtask

   task automatic check_two_writes(input string tag, input logic [7:0] a0, input logic [15:0] d0,
                                   input logic [7:0] a1, input logic [15:0] d1);
      total++;
      if (q_addr.size() !== 2) begin
         bad++; $display("FAIL %s_write_count got=%0d exp=2", tag, q_addr.size());
      end else begin
         total++;
         if (q_addr[0] !== a0 || q_data[0] !== d0) begin
            bad++; $display("FAIL %s_write0 got=%h/%h exp=%h/%h", tag, q_addr[0], q_data[0], a0, d0);
         end
         total++;
         if (q_addr[1] !== a1 || q_data[1] !== d1) begin
            bad++; $display("FAIL %s_write1 got=%h/%h exp=%h/%h", tag, q_addr[1], q_data[1], a1, d1);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; frame_active = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
      #3;
      total++;
      if ({wr_en, wr_addr, wr_data, frame_done, frame_err, busy} !== 28'd0) begin
         bad++; $display("FAIL reset_outputs got=%h exp=0",
                         {wr_en, wr_addr, wr_data, frame_done, frame_err, busy});
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_ignored_byte();
      byte_in = 8'h44; byte_valid = 1'b1; frame_active = 1'b0;
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
      total++;
      if (busy !== 1'b0 || frame_err !== 1'b0) begin
         bad++; $display("FAIL ignored_byte busy=%b err=%b exp=0/0", busy, frame_err);
      end
   endtask

   task automatic test_nominal();
      clear_log();
      send(8'h10);
      total++;
      if (busy !== 1'b1) begin
         bad++; $display("FAIL nominal_busy_rise got=%b exp=1", busy);
      end
      send(8'h02); send(8'h34); send(8'h12);
      total++;
      if (wr_en !== 1'b1 || wr_addr !== 8'h10 || wr_data !== 16'h1234) begin
         bad++; $display("FAIL nominal_first_write en=%b addr=%h data=%h exp=1/10/1234", wr_en, wr_addr, wr_data);
      end
      send(8'hCD); send(8'hAB); send(8'h52);
      total++;
      if (frame_done !== 1'b1 || frame_err !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL nominal_done_cycle done=%b err=%b busy=%b exp=1/0/0", frame_done, frame_err, busy);
      end
      frame_active = 1'b0;
      idle_cycles(2);
      total++;
      if (frame_done !== 1'b0) begin
         bad++; $display("FAIL nominal_done_one_cycle got=%b exp=0", frame_done);
      end
      check_two_writes("nominal", 8'h10, 16'h1234, 8'h11, 16'hABCD);
      total++;
      if (n_done !== 1 || n_err !== 0) begin
         bad++; $display("FAIL nominal_pulses done=%0d err=%0d exp=1/0", n_done, n_err);
      end
      total++;
      if (wr_addr !== 8'h11 || wr_data !== 16'hABCD) begin
         bad++; $display("FAIL nominal_hold addr=%h data=%h exp=11/abcd", wr_addr, wr_data);
      end
   endtask

   task automatic test_empty();
      clear_log();
      send(8'h05); send(8'h00); send(8'h05);
      frame_active = 1'b0;
      idle_cycles(2);
      total++;
      if (q_addr.size() !== 0 || n_done !== 1 || n_err !== 0) begin
         bad++; $display("FAIL empty_frame writes=%0d done=%0d err=%0d exp=0/1/0", q_addr.size(), n_done, n_err);
      end
   endtask

   task automatic test_wrap();
      clear_log();
      send(8'hFF); send(8'h02); send(8'h01); send(8'h00);
      send(8'h02); send(8'h00); send(8'hFE);
      frame_active = 1'b0;
      idle_cycles(2);
      check_two_writes("wrap", 8'hFF, 16'h0001, 8'h00, 16'h0002);
      total++;
      if (n_done !== 1 || n_err !== 0) begin
         bad++; $display("FAIL wrap_pulses done=%0d err=%0d exp=1/0", n_done, n_err);
      end
   endtask

   task automatic test_bad_checksum();
      clear_log();
      send(8'h10); send(8'h02); send(8'h34); send(8'h12);
      send(8'hCD); send(8'hAB); send(8'h53);
      frame_active = 1'b0;
      idle_cycles(2);
      check_two_writes("badchk", 8'h10, 16'h1234, 8'h11, 16'hABCD);
      total++;
      if (n_done !== 0 || n_err !== 1) begin
         bad++; $display("FAIL badchk_pulses done=%0d err=%0d exp=0/1", n_done, n_err);
      end
   endtask

   task automatic test_abort();
      clear_log();
      send(8'h20); send(8'h01); send(8'h55);
      // Last byte of the word arrives as chip-select drops: abort must win.
      byte_in = 8'h66; byte_valid = 1'b1; frame_active = 1'b0;
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
      total++;
      if (frame_err !== 1'b1 || busy !== 1'b0 || wr_en !== 1'b0) begin
         bad++; $display("FAIL abort_cycle err=%b busy=%b wr_en=%b exp=1/0/0", frame_err, busy, wr_en);
      end
      idle_cycles(2);
      total++;
      if (q_addr.size() !== 0 || n_err !== 1 || n_done !== 0) begin
         bad++; $display("FAIL abort_pulses writes=%0d err=%0d done=%0d exp=0/1/0", q_addr.size(), n_err, n_done);
      end
      clear_log();
      send_nominal();
      frame_active = 1'b0;
      idle_cycles(2);
      check_two_writes("after_abort", 8'h10, 16'h1234, 8'h11, 16'hABCD);
      total++;
      if (n_done !== 1 || n_err !== 0) begin
         bad++; $display("FAIL after_abort_pulses done=%0d err=%0d exp=1/0", n_done, n_err);
      end
   endtask

   task automatic test_reset_mid_frame();
      clear_log();
      send(8'h10); send(8'h02); send(8'h34);
      #2;
      rst = 1'b1;
      #1;
      total++;
      if ({wr_en, wr_addr, wr_data, frame_done, frame_err, busy} !== 28'd0) begin
         bad++; $display("FAIL reset_mid_frame got=%h exp=0",
                         {wr_en, wr_addr, wr_data, frame_done, frame_err, busy});
      end
      frame_active = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      idle_cycles(1);
      clear_log();
      send_nominal();
      frame_active = 1'b0;
      idle_cycles(2);
      check_two_writes("after_reset", 8'h10, 16'h1234, 8'h11, 16'hABCD);
   endtask

   task automatic test_back_to_back();
      clear_log();
      send_nominal();
      send(8'h05); send(8'h00); send(8'h05);
      send(8'hFF); send(8'h02); send(8'h01); send(8'h00);
      send(8'h02); send(8'h00); send(8'hFE);
      frame_active = 1'b0;
      idle_cycles(2);
      total++;
      if (q_addr.size() !== 4 || n_done !== 3 || n_err !== 0) begin
         bad++; $display("FAIL b2b_counts writes=%0d done=%0d err=%0d exp=4/3/0", q_addr.size(), n_done, n_err);
      end else begin
         total++;
         if (q_addr[2] !== 8'hFF || q_data[2] !== 16'h0001 || q_addr[3] !== 8'h00 || q_data[3] !== 16'h0002) begin
            bad++; $display("FAIL b2b_third_frame got=%h/%h %h/%h exp=ff/0001 00/0002",
                            q_addr[2], q_data[2], q_addr[3], q_data[3]);
         end
      end
   endtask

   initial begin
      clear_log();
      test_reset();
      test_ignored_byte();
      test_nominal();
      test_empty();
      test_wrap();
      test_bad_checksum();
      test_abort();
      test_reset_mid_frame();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
